// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide unit with the architectural HI/LO pair.
// A multiply takes one cycle and a divide takes DATA_W cycles; both then wait in DONE.
// Results reach HI/LO only when the instruction leaves EXE unflushed.
module exe_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              adv_i,
  input  logic              valid_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   res_hi_q, res_lo_q;
  logic [CNT_W-1:0]    cnt_q;
  // op_a_q doubles as the dividend/quotient shift register during a divide.
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [DATA_W-1:0]   rem_q;
  logic                signed_q;
  logic                quo_neg_q;
  logic                rem_neg_q;

  logic                is_mul_op, is_div_op, is_signed_op, issue;
  logic                commit, mt_write;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] a_ext, b_ext, product;
  logic [DATA_W:0]     rem_shift, rem_diff;
  logic                quo_bit;
  logic [DATA_W-1:0]   rem_next, quo_next, quo_final, rem_final;

  // Issue decode and HI/LO write qualifiers.
  always_comb begin
    is_mul_op    = (op_i == OP_MULT) || (op_i == OP_MULTU);
    is_div_op    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    is_signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    issue        = valid_i && !flush_i && (is_mul_op || is_div_op) && (state_q == ST_IDLE);
    commit       = (state_q == ST_DONE) && adv_i && !flush_i;
    mt_write     = (state_q == ST_IDLE) && valid_i && adv_i && !flush_i;
    // Two's-complement negate leaves the most negative value as itself, which reads
    // correctly as its unsigned magnitude.
    abs_a = (is_signed_op && src_a_i[DATA_W-1]) ? (~src_a_i + 1'b1) : src_a_i;
    abs_b = (is_signed_op && src_b_i[DATA_W-1]) ? (~src_b_i + 1'b1) : src_b_i;
  end

  // Multiplier and one restoring-division step.
  always_comb begin
    // The low 2*DATA_W bits of a product of sign-extended operands equal the signed product.
    a_ext     = {{DATA_W{signed_q & op_a_q[DATA_W-1]}}, op_a_q};
    b_ext     = {{DATA_W{signed_q & op_b_q[DATA_W-1]}}, op_b_q};
    product   = a_ext * b_ext;
    rem_shift = {rem_q, op_a_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, op_b_q};
    quo_bit   = !rem_diff[DATA_W];
    rem_next  = quo_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    quo_next  = {op_a_q[DATA_W-2:0], quo_bit};
    quo_final = quo_neg_q ? (~quo_next + 1'b1) : quo_next;
    rem_final = rem_neg_q ? (~rem_next + 1'b1) : rem_next;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush abandons any operation in flight.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (issue) state_d = is_mul_op ? ST_MUL : ST_DIV;
        ST_MUL:  state_d = ST_DONE;
        ST_DIV:  if (cnt_q == '0) state_d = ST_DONE;
        ST_DONE: if (adv_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: hold the pipe from issue until the result is ready.
  always_comb begin
    stall_o = !flush_i && (issue || (state_q == ST_MUL) || (state_q == ST_DIV));
    busy_o  = (state_q != ST_IDLE);
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

  // Operand latching, multiply result and divider iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            signed_q  <= is_signed_op;
            op_a_q    <= is_div_op ? abs_a : src_a_i;
            op_b_q    <= is_div_op ? abs_b : src_b_i;
            quo_neg_q <= is_signed_op && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
            rem_neg_q <= is_signed_op && src_a_i[DATA_W-1];
            rem_q     <= '0;
            cnt_q     <= CNT_W'(DATA_W - 1);
          end
        end
        ST_MUL: begin
          res_hi_q <= product[2*DATA_W-1:DATA_W];
          res_lo_q <= product[DATA_W-1:0];
        end
        ST_DIV: begin
          rem_q  <= rem_next;
          op_a_q <= quo_next;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            res_hi_q <= rem_final;
            res_lo_q <= quo_final;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: result commit on leaving DONE, or a direct move from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= res_hi_q;
      lo_q <= res_lo_q;
    end else if (mt_write) begin
      if (op_i == OP_MTHI) hi_q <= src_a_i;
      if (op_i == OP_MTLO) lo_q <= src_a_i;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit: multiply, divide, corner divides, flush,
// DONE hold with back-to-back issue, HI/LO moves and reset during a divide.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        adv_i;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exe_muldiv_unit #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .adv_i   (adv_i),
    .valid_i (valid_i),
    .op_i    (op_i),
    .src_a_i (src_a_i),
    .src_b_i (src_b_i),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o)
  );

  // Issue one op with adv_i=1 and count stall cycles until the unit releases the pipe.
  // Returns after the commit edge with valid_i dropped.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output bit timed_out);
    @(negedge clk);
    valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b; adv_i = 1'b1; flush_i = 1'b0;
    stalls = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_o) begin
        timed_out = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; adv_i = 1'b0; valid_i = 1'b0;
    op_i = 3'd0; src_a_i = '0; src_b_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi_o); end
    checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo_o); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: hi=%h lo=%h busy=%0b", hi_o, lo_o, busy_o);
  endtask

  task automatic test_mul();
    int st; bit to;
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, st, to);
    $display("MULT fffffffe*3: stalls=%0d hi=%h lo=%h", st, hi_o, lo_o);
    checks++; if (to || st != 2) begin failures++; $display("FAIL mult_stall got=%0d timeout=%0b exp=2", st, to); end
    checks++; if (hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo_o); end
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, st, to);
    $display("MULTU fffffffe*3: stalls=%0d hi=%h lo=%h", st, hi_o, lo_o);
    checks++; if (to || st != 2) begin failures++; $display("FAIL multu_stall got=%0d timeout=%0b exp=2", st, to); end
    checks++; if (hi_o !== 32'h00000002) begin failures++; $display("FAIL multu_hi got=%h exp=00000002", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffa", lo_o); end
  endtask

  task automatic test_div();
    int st; bit to;
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, st, to);
    $display("DIV -7/2: stalls=%0d hi=%h lo=%h", st, hi_o, lo_o);
    checks++; if (to || st != 33) begin failures++; $display("FAIL div_stall got=%0d timeout=%0b exp=33", st, to); end
    checks++; if (lo_o !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo_o); end
    checks++; if (hi_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi_o); end
    run_op(3'd4, 32'd100, 32'd7, st, to);
    $display("DIVU 100/7: stalls=%0d hi=%h lo=%h", st, hi_o, lo_o);
    checks++; if (to || st != 33) begin failures++; $display("FAIL divu_stall got=%0d timeout=%0b exp=33", st, to); end
    checks++; if (lo_o !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", lo_o); end
    checks++; if (hi_o !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", hi_o); end
  endtask

  task automatic test_div_corner();
    int st; bit to;
    run_op(3'd4, 32'h00001234, 32'd0, st, to);
    $display("DIVU 1234/0: stalls=%0d hi=%h lo=%h", st, hi_o, lo_o);
    checks++; if (hi_o !== 32'h00001234) begin failures++; $display("FAIL divu0_hi got=%h exp=00001234", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo_o); end
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, st, to);
    $display("DIV 80000000/-1: stalls=%0d hi=%h lo=%h", st, hi_o, lo_o);
    checks++; if (lo_o !== 32'h80000000) begin failures++; $display("FAIL divmin_lo got=%h exp=80000000", lo_o); end
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL divmin_hi got=%h exp=00000000", hi_o); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'h11; adv_i = 1'b1; flush_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%0b exp=0", stall_o); end
    @(negedge clk);
    op_i = 3'd6; src_a_i = 32'h22;
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0;
    #1;
    checks++; if (hi_o !== 32'h11 || lo_o !== 32'h22) begin failures++; $display("FAIL preset_hilo got=%h/%h exp=00000011/00000022", hi_o, lo_o); end
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd3; src_a_i = 32'd100; src_b_i = 32'd3;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall_o); end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    $display("DIV flushed at cycle 10: busy=%0b stall=%0b hi=%h lo=%h", busy_o, stall_o, hi_o, lo_o);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b exp=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_idle_stall got=%0b exp=0", stall_o); end
    checks++; if (hi_o !== 32'h11) begin failures++; $display("FAIL flush_hi got=%h exp=00000011", hi_o); end
    checks++; if (lo_o !== 32'h22) begin failures++; $display("FAIL flush_lo got=%h exp=00000022", lo_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd1; src_a_i = 32'd5; src_b_i = 32'd6; adv_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL hold_stall[%0d] got=%0b exp=0", i, stall_o); end
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL hold_busy[%0d] got=%0b exp=1", i, busy_o); end
      checks++; if (lo_o !== 32'h22) begin failures++; $display("FAIL hold_lo[%0d] got=%h exp=00000022", i, lo_o); end
      @(negedge clk);
    end
    adv_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL commit_stall got=%0b exp=0", stall_o); end
    @(negedge clk);
    src_a_i = 32'd7; src_b_i = 32'd8;
    #1;
    $display("MULT 5*6 held 3 cycles then committed: hi=%h lo=%h", hi_o, lo_o);
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'd30) begin failures++; $display("FAIL hold_commit got=%h/%h exp=00000000/0000001e", hi_o, lo_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL b2b_issue_stall got=%0b exp=1", stall_o); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0;
    #1;
    $display("MULT 7*8 back-to-back: hi=%h lo=%h", hi_o, lo_o);
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'd56) begin failures++; $display("FAIL b2b_result got=%h/%h exp=00000000/00000038", hi_o, lo_o); end
  endtask

  task automatic test_mt();
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'hDEADBEEF; adv_i = 1'b1; flush_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL mthi2_stall got=%0b exp=0", stall_o); end
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    $display("MTHI deadbeef: hi=%h", hi_o);
    checks++; if (hi_o !== 32'hDEADBEEF) begin failures++; $display("FAIL mthi_hi got=%h exp=deadbeef", hi_o); end
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd6; src_a_i = 32'h00000999; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0; op_i = 3'd0;
    #1;
    $display("MTLO 999 flushed: lo=%h", lo_o);
    checks++; if (lo_o !== 32'd56) begin failures++; $display("FAIL mtlo_flush_lo got=%h exp=00000038", lo_o); end
  endtask

  task automatic test_rst_mid_div();
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd3; src_a_i = 32'd1000; src_b_i = 32'd3; adv_i = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL middiv_busy got=%0b exp=1", busy_o); end
    rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset during DIV: busy=%0b hi=%h lo=%h", busy_o, hi_o, lo_o);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstdiv_busy got=%0b exp=0", busy_o); end
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin failures++; $display("FAIL rstdiv_hilo got=%h/%h exp=00000000/00000000", hi_o, lo_o); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_corner();
    test_flush();
    test_back_to_back();
    test_mt();
    test_rst_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit and architectural HI/LO register pair for the EXE stage.
- Consumes the EXE pipeline-register outputs (BusA, BusB, decoded mul/div op) and stalls the front of the pipe while busy.
- Commits results to HI/LO only when the instruction leaves EXE unflushed, so HI/LO state stays precise.

Parameters:
- DATA_W, 32, operand/HI/LO width. Only 32 is supported; the divider iterates DATA_W times.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  EXE flush (older exception/eret); cancels the in-flight op
- adv_i  in  1  EXE instruction advances to MEM this cycle
- valid_i  in  1  EXE holds a valid, non-excepting instruction
- op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- src_a_i  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b_i  in  32  rt operand (divisor / multiplier)
- stall_o  out  1  hold EXE and all upstream stages
- hi_o  out  32  committed HI
- lo_o  out  32  committed LO
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, HI=LO=0, result buffers=0, count=0, stall_o=0, busy_o=0.
- States: IDLE, MUL, DIV, DONE.
- issue = valid_i & !flush_i & op_i in {1..4} & state==IDLE.
- stall_o (combinational):
  - 1 when issue is true;
  - 1 in MUL and DIV;
  - 0 in IDLE with no issue, and 0 in DONE.
- IDLE, on issue:
  - latch operands and the signed flag;
  - MULT/MULTU → MUL;
  - DIV/DIVU → DIV with count=DATA_W-1, magnitudes latched: signed ops take abs(); 0x80000000 stays 0x80000000 as unsigned.
- MUL, one cycle:
  - compute the 64-bit product (signed for MULT, unsigned for MULTU) into res_hi/res_lo;
  - → DONE.
- DIV:
  - restoring radix-2, one quotient bit per cycle;
  - at count==0, apply sign correction: quotient negated if the operand signs differ; remainder takes the sign of the dividend;
  - write res_hi=remainder, res_lo=quotient → DONE.
  - Total stall: 1 issue cycle + 32 DIV cycles = 33 cycles.
- Divide by zero: no exception, no special-casing; the result is whatever the algorithm yields (DIVU x/0: HI=x, LO=0xFFFFFFFF).
- 0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
- DONE:
  - stall_o=0 so the instruction may advance;
  - when adv_i & !flush_i: HI<=res_hi, LO<=res_lo, → IDLE;
  - when !adv_i: remain in DONE, with no re-issue of the same instruction.
- MTHI/MTLO:
  - no state change, no stall;
  - HI (or LO) <= src_a_i at the edge where valid_i & adv_i & !flush_i & state==IDLE.
- flush_i=1 in any state: → IDLE next edge; no HI/LO write; result buffers discarded; stall_o=0 that cycle.
- rst has priority over flush_i; reset mid-divide returns to IDLE with HI=LO=0.
- hi_o/lo_o always reflect committed registers: an MFHI in EXE the cycle after commit sees the new value. No speculative forwarding of res_hi/res_lo.
- op_i, src_a_i and src_b_i need only be valid in the issue cycle; they are latched internally. EXE holds them anyway, because stall_o freezes its register.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, valid, adv_i=1 → stall_o high for 2 cycles; after commit HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=-7, b=2 → stall_o high exactly 33 cycles; after commit LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIVU 0x1234/0 → HI=0x00001234, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV issued, flush_i asserted on DIV cycle 10 → IDLE next cycle, stall_o=0, HI/LO keep their prior values (e.g. 0x11/0x22).
- MULT reaches DONE with adv_i=0 for 3 cycles → stall_o=0, no re-issue, HI/LO unchanged; adv_i=1 → commit in that cycle. Back-to-back MULT is then accepted the following cycle.
- MTHI 0xDEADBEEF with adv_i=1 → hi_o=0xDEADBEEF next cycle. MTLO with flush_i=1 → LO unchanged. rst during DIV → busy_o=0, HI=LO=0 next cycle.
